// File: rtl/hash_serial_host.sv
// rtl/hash_serial_host.sv - host-side bit-serial driver for the hashing core
module hash_serial_host #(
    parameter int Y         = 64,
    parameter int L         = 256,
    parameter int START_LEN = 5,
    parameter int READ_GAP  = 2,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Y-1:0]     msg_in,
    input  logic             req_valid,
    output logic             req_ready,
    output logic             messagexSO,
    output logic             startxSO,
    input  logic             hash_digestxSI,
    input  logic             hash_readyxSI,
    output logic [L-1:0]     digest_out,
    output logic             digest_valid,
    input  logic             digest_ready,
    output logic [CNT_W-1:0] latency_cycles
);

    localparam int BW = $clog2(((Y > L) ? Y : L) + 1);
    localparam int SW = $clog2(START_LEN + 1);
    localparam int GW = (READ_GAP > 0) ? $clog2(READ_GAP + 1) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SHIFT = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_READ  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]       state;
    logic [Y-1:0]     shreg;
    logic [BW-1:0]    bit_cnt;
    logic [SW-1:0]    start_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [CNT_W-1:0] lat_cnt;
    logic [CNT_W-1:0] lat_next;

    // Saturating increment of the running latency counter
    always_comb begin
        lat_next = (&lat_cnt) ? lat_cnt : lat_cnt + CNT_W'(1);
    end

    // Outputs decoded directly from the state so reset/abort clears them at once
    always_comb begin
        req_ready    = (state == S_IDLE);
        messagexSO   = (state == S_SHIFT) ? shreg[Y-1] : 1'b0;
        startxSO     = (state == S_START);
        digest_valid = (state == S_DONE);
    end

    // Main sequencer: shift message out, pulse start, wait, then collect digest
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            shreg          <= '0;
            bit_cnt        <= '0;
            start_cnt      <= '0;
            gap_cnt        <= '0;
            lat_cnt        <= '0;
            latency_cycles <= '0;
            digest_out     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        shreg   <= msg_in;
                        bit_cnt <= '0;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shreg <= {shreg[Y-2:0], 1'b0};
                    if (int'(bit_cnt) == Y - 1) begin
                        start_cnt <= '0;
                        lat_cnt   <= CNT_W'(1);
                        state     <= S_START;
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
                S_START: begin
                    lat_cnt <= lat_next;
                    if (int'(start_cnt) == START_LEN - 1) begin
                        state <= S_WAIT;
                    end else begin
                        start_cnt <= start_cnt + SW'(1);
                    end
                end
                S_WAIT: begin
                    lat_cnt <= lat_next;
                    if (hash_readyxSI) begin
                        latency_cycles <= lat_cnt;
                        gap_cnt        <= '0;
                        bit_cnt        <= '0;
                        state          <= (READ_GAP == 0) ? S_READ : S_GAP;
                    end
                end
                S_GAP: begin
                    if (int'(gap_cnt) == READ_GAP - 1) begin
                        state <= S_READ;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                S_READ: begin
                    for (int i = 0; i < L; i++) begin
                        if (int'(bit_cnt) == i) begin
                            digest_out[i] <= hash_digestxSI;
                        end
                    end
                    if (int'(bit_cnt) == L - 1) begin
                        state <= S_DONE;
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
                S_DONE: begin
                    if (digest_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
